// File: rtl/xor_parity_rx_pkg.sv
// Shared types and line-level constants for the XOR parity serial link.
package xor_parity_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/xor_parity_acc.sv
// One-bit XOR accumulator with clear and enable; shared by the link transmitter and receiver.
module xor_parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  // Clear wins over enable so a new frame always starts from zero parity.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/xor_parity_rx.sv
// Serial receiver for start/data/parity/stop frames with XOR parity checking.
// Optional error/frame statistics counters are enabled by defining XOR_PARITY_RX_STATS_EN.
module xor_parity_rx
  import xor_parity_pkg::*;
#(
  parameter int n   = 4,
  parameter bit ODD = 1'b0,
  parameter int CW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bit_en,
  input  logic          rx_bit,
  output logic [n-1:0]  data_o,
  output logic          valid_o,
  output logic          parity_err_o,
  output logic          frame_err_o,
`ifdef XOR_PARITY_RX_STATS_EN
  output logic [CW-1:0] frame_cnt_o,
  output logic [CW-1:0] perr_cnt_o,
  output logic [CW-1:0] ferr_cnt_o,
`endif
  output logic          busy_o
);

  localparam int CNT_W = (n > 1) ? $clog2(n) : 1;

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [n-1:0]     shift_q;
  logic             acc, acc_clr, acc_en;
  logic             start_frame, data_bit, parity_bit, stop_bit, last_bit;
  logic             perr_q, ferr_q, done_q;

  xor_parity_acc u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (acc_clr),
    .en   (acc_en),
    .d    (rx_bit),
    .acc  (acc)
  );

  assign last_bit = (cnt_q == CNT_W'(n - 1));
  assign busy_o   = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every state step is gated by the bit strobe; without it the frame simply waits.
  always_comb begin
    state_d     = state_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    start_frame = 1'b0;
    data_bit    = 1'b0;
    parity_bit  = 1'b0;
    stop_bit    = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (rx_bit == START_BIT) begin
            state_d     = DATA;
            acc_clr     = 1'b1;
            start_frame = 1'b1;
          end
        end
        DATA: begin
          acc_en   = 1'b1;
          data_bit = 1'b1;
          if (last_bit) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_bit = 1'b1;
          state_d    = STOP;
        end
        STOP: begin
          stop_bit = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The word is published one clock after the stop strobe; shift_q survives that
  // clock even when a back-to-back start bit clears it on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      done_q       <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      done_q  <= stop_bit;
      valid_o <= done_q;
      if (start_frame) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end
      if (data_bit) begin
        for (int i = 0; i < n; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            shift_q[i] <= rx_bit;
          end
        end
        if (!last_bit) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (parity_bit) begin
        perr_q <= acc ^ rx_bit ^ ODD;
      end
      if (stop_bit) begin
        ferr_q <= (rx_bit != STOP_BIT);
      end
      if (done_q) begin
        data_o       <= shift_q;
        parity_err_o <= perr_q;
        frame_err_o  <= ferr_q;
      end
    end
  end

`ifdef XOR_PARITY_RX_STATS_EN
  // Saturating counters so a long-running link never wraps back to small values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_o <= '0;
      perr_cnt_o  <= '0;
      ferr_cnt_o  <= '0;
    end else if (valid_o) begin
      if (frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 1'b1;
      if (parity_err_o && perr_cnt_o != '1) perr_cnt_o <= perr_cnt_o + 1'b1;
      if (frame_err_o && ferr_cnt_o != '1) ferr_cnt_o <= ferr_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
- Serial receiver for parity-protected words; the receive end of the XOR parity link whose transmitter computes parity as the XOR reduction of an n-bit word.
- Deserialises a framed bit stream into n-bit words and recomputes parity with an XOR accumulator.
- Flags parity and framing errors.
- Sits after the serial line and bit-timing logic in the ch2 gate/datapath examples; the downstream consumer samples a one-cycle valid pulse.

Parameters:
- n, 4, data word width in bits (n >= 1)
- ODD, 0, 0 = even parity, 1 = odd parity
- CW, 8, width of error counters (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- bit_en  input  1  bit strobe; rx_bit is sampled only on cycles where bit_en=1
- rx_bit  input  1  serial line; idles high
- data_o  output  n  last received word
- valid_o  output  1  one-cycle pulse when a frame completes
- parity_err_o  output  1  parity mismatch for the frame; valid when valid_o=1
- frame_err_o  output  1  stop bit was 0; valid when valid_o=1
- busy_o  output  1  high while a frame is in progress

Behaviour:
- Reset: rst_n low at a rising edge clears everything.
  - State -> IDLE.
  - data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0.
  - Shift register, bit counter and parity accumulator cleared.
- Frame format, LSB first: start(0), d[0]..d[n-1], parity, stop(1).
  - The transmitter's parity bit is ^data for even parity and ~^data for odd parity.
- States: IDLE, DATA, PARITY, STOP. All transitions happen only on cycles with bit_en=1; otherwise all state is held.
  - IDLE: rx_bit=0 -> DATA, clear counter and accumulator. rx_bit=1 -> stay in IDLE.
  - DATA: shift rx_bit into bit position cnt and XOR it into the accumulator. When cnt=n-1 -> PARITY, else cnt+1.
  - PARITY: store the expected-vs-received comparison as acc ^ rx_bit ^ ODD (nonzero = error) -> STOP.
  - STOP: -> IDLE, and on the next clock edge:
    - valid_o=1 for exactly one cycle;
    - data_o = assembled word;
    - parity_err_o = stored comparison;
    - frame_err_o = ~rx_bit.
- Latency: valid_o rises one clk after the edge on which the stop bit is sampled.
- Output hold: data_o, parity_err_o and frame_err_o hold until the next frame completes. valid_o is 0 on all other cycles.
- busy_o = 1 in DATA, PARITY and STOP; 0 in IDLE.
- Simultaneous errors: parity and framing errors are independent; both may be 1 in the same frame. The word is delivered regardless of error flags.
- Back-to-back frames: a start bit on the strobe immediately after the stop bit is accepted. No idle bit is required.
- Reset mid-frame: the partial frame is discarded, no valid_o is produced, and reception resumes from IDLE.
- No start-bit glitch filtering or mid-bit sampling; bit timing is the strobe source's job.

Optional Feature:
- Macro: XOR_PARITY_RX_STATS_EN.
- Defined:
  - adds outputs frame_cnt_o, perr_cnt_o and ferr_cnt_o, each CW bits wide;
  - counters increment on valid_o and on the respective error flag;
  - counters saturate at 2^CW-1 and reset to 0 on rst_n.
- Not defined: these ports and their logic do not exist; all other behaviour is identical.

Decomposition:
- Package xor_parity_pkg:
  - typedef enum logic [1:0] rx_state_t {IDLE, DATA, PARITY, STOP};
  - localparams for the start bit (0) and stop bit (1) values.
- Sub-module xor_parity_acc: 1-bit XOR accumulator with clear and enable. It is reused by the matching transmitter.

Test Plan:
- n=4, even parity, bits 0,0,1,0,1,0,1 (start, data for 4'b1010, parity 0, stop 1), bit_en every cycle -> valid_o pulses once, data_o=4'b1010, parity_err_o=0, frame_err_o=0.
- Word 4'b1100 sent with parity 1 (even mode) -> data_o=4'b1100, parity_err_o=1, frame_err_o=0. The same frame with ODD=1 -> parity_err_o=0.
- Word 4'b1111, parity 0, stop 0 -> data_o=4'b1111, frame_err_o=1, parity_err_o=0. A second frame with stop 0 and a bad parity bit -> both flags = 1.
- Frame 4'b0101 with bit_en high only every 3rd cycle -> same result as the continuous case. valid_o is exactly one cycle wide; busy_o is high from the start strobe until the stop strobe.
- rst_n low for one cycle after 2 data bits, then a full frame for 4'b0011 -> no valid_o from the aborted frame; the next valid_o shows data_o=4'b0011.
- Back-to-back frames 4'b1010 then 4'b0110 with no idle bit -> two valid_o pulses with correct data. With XOR_PARITY_RX_STATS_EN defined, frame_cnt_o=2.
